// File: rtl/dac_pkg.sv
// Shared types, widths and frame builder for the SPI DAC master.
package dac_pkg;

  localparam int unsigned FRAME_W  = 16;
  localparam int unsigned SAMPLE_W = 10;
  localparam int unsigned CFG_W    = 4;

  // A/B=0, BUF=0, GA=1 (1x gain), SHDN=1 (output active)
  localparam logic [CFG_W-1:0] DEF_CFG_BITS = 4'b0011;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_SETUP = 3'd1;
  localparam state_t ST_SHIFT = 3'd2;
  localparam state_t ST_HOLD  = 3'd3;
  localparam state_t ST_LATCH = 3'd4;

  function automatic logic [FRAME_W-1:0] build_frame(input logic [CFG_W-1:0]    cfg,
                                                     input logic [SAMPLE_W-1:0] smp);
    return {cfg, smp, 2'b00};
  endfunction

endpackage

// File: rtl/sck_tick_gen.sv
// Free-running divider that pulses tick_c on its terminal count; held at zero by clr_i.
module sck_tick_gen #(
  parameter int unsigned DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  output logic tick_c
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign tick_c = !clr_i && (cnt_q == CW'(DIV - 1));

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (clr_i || tick_c) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/spi_dac_master.sv
// Mode-0 SPI master feeding a 16-bit-frame 10-bit DAC, with a 1-deep latest-wins sample buffer.
module spi_dac_master
  import dac_pkg::*;
#(
  parameter int unsigned      CLK_DIV  = 4,
  parameter logic [CFG_W-1:0] CFG_BITS = DEF_CFG_BITS
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [SAMPLE_W-1:0] sample,
  input  logic                sample_valid,
  input  logic                clr_overrun,
  output logic                dac_sck,
  output logic                dac_sdi,
  output logic                dac_cs_n,
  output logic                dac_ldac_n,
  output logic                busy,
  output logic                frame_done,
  output logic                overrun
);

  localparam int unsigned SH_W  = FRAME_W - 1;
  localparam int unsigned BIT_W = $clog2(FRAME_W);

  state_t              state_q, state_d;
  logic                sck_q, sck_d;
  logic                sdi_q, sdi_d;
  logic                cs_n_q, cs_n_d;
  logic                ldac_n_q, ldac_n_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                ovr_q, ovr_d;
  logic                pend_full_q, pend_full_d;
  logic [SAMPLE_W-1:0] pend_q, pend_d;
  logic [SH_W-1:0]     shreg_q, shreg_d;
  logic [BIT_W-1:0]    bit_q, bit_d;
  logic                ovr_set;
  logic                idle_c;
  logic                tick_c;
  logic [FRAME_W-1:0]  frame_c;

  assign idle_c  = (state_q == ST_IDLE);
  // Buffered sample always goes out before a live strobe
  assign frame_c = build_frame(CFG_BITS, pend_full_q ? pend_q : sample);

  sck_tick_gen #(
    .DIV (CLK_DIV)
  ) u_tick (
    .clk    (clk),
    .reset  (reset),
    .clr_i  (idle_c),
    .tick_c (tick_c)
  );

  always_comb begin
    state_d     = state_q;
    sck_d       = sck_q;
    sdi_d       = sdi_q;
    cs_n_d      = cs_n_q;
    ldac_n_d    = ldac_n_q;
    done_d      = 1'b0;
    pend_full_d = pend_full_q;
    pend_d      = pend_q;
    shreg_d     = shreg_q;
    bit_d       = bit_q;
    ovr_set     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (pend_full_q || sample_valid) begin
          shreg_d = frame_c[SH_W-1:0];
          sdi_d   = frame_c[FRAME_W-1];
          cs_n_d  = 1'b0;
          bit_d   = '0;
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (tick_c) begin
          sck_d   = 1'b1;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (tick_c) begin
          sck_d = !sck_q;
          // Data advances on falling edges; the 16th fall keeps the last bit on the line
          if (sck_q) begin
            if (bit_q == BIT_W'(FRAME_W - 1)) begin
              state_d = ST_HOLD;
            end else begin
              sdi_d   = shreg_q[SH_W-1];
              shreg_d = {shreg_q[SH_W-2:0], 1'b0};
              bit_d   = bit_q + BIT_W'(1);
            end
          end
        end
      end
      ST_HOLD: begin
        if (tick_c) begin
          cs_n_d   = 1'b1;
          sdi_d    = 1'b0;
          ldac_n_d = 1'b0;
          state_d  = ST_LATCH;
        end
      end
      ST_LATCH: begin
        if (tick_c) begin
          ldac_n_d = 1'b1;
          done_d   = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (idle_c) begin
      if (pend_full_q) begin
        pend_full_d = sample_valid;
        if (sample_valid) begin
          pend_d = sample;
        end
      end
    end else if (sample_valid) begin
      ovr_set     = pend_full_q;
      pend_full_d = 1'b1;
      pend_d      = sample;
    end

    ovr_d  = ovr_set ? 1'b1 : (clr_overrun ? 1'b0 : ovr_q);
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      sck_q       <= 1'b0;
      sdi_q       <= 1'b0;
      cs_n_q      <= 1'b1;
      ldac_n_q    <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      ovr_q       <= 1'b0;
      pend_full_q <= 1'b0;
      pend_q      <= '0;
      shreg_q     <= '0;
      bit_q       <= '0;
    end else begin
      state_q     <= state_d;
      sck_q       <= sck_d;
      sdi_q       <= sdi_d;
      cs_n_q      <= cs_n_d;
      ldac_n_q    <= ldac_n_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      ovr_q       <= ovr_d;
      pend_full_q <= pend_full_d;
      pend_q      <= pend_d;
      shreg_q     <= shreg_d;
      bit_q       <= bit_d;
    end
  end

  assign dac_sck    = sck_q;
  assign dac_sdi    = sdi_q;
  assign dac_cs_n   = cs_n_q;
  assign dac_ldac_n = ldac_n_q;
  assign busy       = busy_q;
  assign frame_done = done_q;
  assign overrun    = ovr_q;

endmodule

// File: tb/tb_spi_dac_master.sv
// Scoreboard bench for spi_dac_master at CLK_DIV=4 and CLK_DIV=2 against a transaction-level model.
module tb_spi_dac_master;

  localparam int TP0 = 4;
  localparam int TP1 = 2;

  typedef struct packed {
    logic [15:0] frame;
    logic [31:0] start;
  } exp_t;

  logic       clk = 1'b0;
  logic [1:0] rst, sv, clr;
  logic [9:0] smp [2];
  logic [1:0] sck, sdi, csn, ldacn, busy, fdone, ovr;

  always #5 clk = ~clk;

  spi_dac_master #(.CLK_DIV(4)) u_dut4 (
    .clk(clk), .reset(rst[0]), .sample(smp[0]), .sample_valid(sv[0]), .clr_overrun(clr[0]),
    .dac_sck(sck[0]), .dac_sdi(sdi[0]), .dac_cs_n(csn[0]), .dac_ldac_n(ldacn[0]),
    .busy(busy[0]), .frame_done(fdone[0]), .overrun(ovr[0])
  );

  spi_dac_master #(.CLK_DIV(2)) u_dut2 (
    .clk(clk), .reset(rst[1]), .sample(smp[1]), .sample_valid(sv[1]), .clr_overrun(clr[1]),
    .dac_sck(sck[1]), .dac_sdi(sdi[1]), .dac_cs_n(csn[1]), .dac_ldac_n(ldacn[1]),
    .busy(busy[1]), .frame_done(fdone[1]), .overrun(ovr[1])
  );

  int   edge_cnt = 0;
  int   pass_cnt = 0;
  int   chk_cnt  = 0;
  exp_t exp_q [2][$];

  // model state, written only by the stimulus process
  logic [1:0] d_rst, d_sv, d_clr;
  logic [9:0] d_val [2];
  int         m_free [2];
  logic [1:0] m_full;
  logic [9:0] m_pend [2];
  logic [1:0] exp_ovr, exp_busy, exp_rst;
  logic       done_flag = 1'b0;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  function automatic exp_t mk(input logic [9:0] v, input int e);
    exp_t x;
    x.frame = 16'h3000 | (16'(v) << 2);
    x.start = 32'(e);
    return x;
  endfunction

  // What the interface does at edge e: frames occupy 34T+1 edges, one buffered sample, latest wins
  task automatic model_edge(input int g, input int e);
    int   t;
    logic set;
    t   = (g == 0) ? TP0 : TP1;
    set = 1'b0;
    exp_rst[g] = d_rst[g];
    if (d_rst[g]) begin
      m_full[g]  = 1'b0;
      m_free[g]  = e + 1;
      exp_ovr[g] = 1'b0;
    end else begin
      if (e >= m_free[g]) begin
        if (m_full[g]) begin
          exp_q[g].push_back(mk(m_pend[g], e));
          m_free[g] = e + 34 * t + 1;
          m_full[g] = d_sv[g];
          m_pend[g] = d_val[g];
        end else if (d_sv[g]) begin
          exp_q[g].push_back(mk(d_val[g], e));
          m_free[g] = e + 34 * t + 1;
        end
      end else if (d_sv[g]) begin
        set       = m_full[g];
        m_full[g] = 1'b1;
        m_pend[g] = d_val[g];
      end
      if (set) exp_ovr[g] = 1'b1;
      else if (d_clr[g]) exp_ovr[g] = 1'b0;
    end
    exp_busy[g] = (e < m_free[g] - 1);
  endtask

  task automatic tick();
    int e;
    e = edge_cnt + 1;
    for (int g = 0; g < 2; g++) begin
      rst[g] = d_rst[g];
      sv[g]  = d_sv[g];
      smp[g] = d_val[g];
      clr[g] = d_clr[g];
      model_edge(g, e);
    end
    @(negedge clk);
    d_rst = '0;
    d_sv  = '0;
    d_clr = '0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic strobe(input int g, input logic [9:0] v, input logic c);
    d_sv[g]  = 1'b1;
    d_val[g] = v;
    d_clr[g] = c;
    tick();
  endtask

  task automatic rand_run(input int g, input int n);
    for (int i = 0; i < n; i++) begin
      d_sv[g]  = ($urandom_range(0, 29) == 0);
      d_val[g] = 10'($urandom);
      d_clr[g] = ($urandom_range(0, 59) == 0);
      d_rst[g] = ($urandom_range(0, 1999) == 0);
      tick();
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic [1:0]  prev_sck = '0;
  logic [1:0]  prev_cs  = '1;
  logic [1:0]  in_fr    = '0;
  logic [1:0]  tim_ok   = '0;
  logic [15:0] bits [2];
  int          nb [2];
  exp_t        cur [2];
  logic        final_done = 1'b0;

  task automatic chk(input bit ok, input string name, input int g, input longint act, input longint req);
    chk_cnt++;
    if (ok) pass_cnt++;
    else $display("FAIL %s dut%0d: got %0h, expected %0h", name, g, act, req);
  endtask

  always @(posedge clk) begin
    #1;
    for (int g = 0; g < 2; g++) begin
      int t;
      int e;
      int s;
      t = (g == 0) ? TP0 : TP1;
      e = edge_cnt;
      chk(busy[g] == exp_busy[g], "busy", g, busy[g], exp_busy[g]);
      chk(ovr[g] == exp_ovr[g], "overrun", g, ovr[g], exp_ovr[g]);
      if (exp_rst[g]) begin
        chk({sck[g], csn[g], ldacn[g], fdone[g]} == 4'b0110, "reset_outputs", g,
            {sck[g], csn[g], ldacn[g], fdone[g]}, 4'b0110);
        in_fr[g] = 1'b0;
      end else begin
        if (prev_cs[g] && !csn[g]) begin
          if (exp_q[g].size() == 0) begin
            chk(1'b0, "unexpected_frame", g, e, 0);
            in_fr[g] = 1'b0;
          end else begin
            cur[g] = exp_q[g].pop_front();
            chk(e == int'(cur[g].start), "cs_fall_edge", g, e, cur[g].start);
            in_fr[g]  = 1'b1;
            nb[g]     = 0;
            bits[g]   = '0;
            tim_ok[g] = 1'b1;
          end
        end
        s = int'(cur[g].start);
        if (in_fr[g]) begin
          chk({csn[g], ldacn[g]} == {(e >= s + 33 * t), !(e >= s + 33 * t && e < s + 34 * t)},
              "cs_ldac_window", g, {csn[g], ldacn[g]},
              {(e >= s + 33 * t), !(e >= s + 33 * t && e < s + 34 * t)});
        end
        if (in_fr[g] && !prev_sck[g] && sck[g]) begin
          if (e != s + (2 * nb[g] + 1) * t) tim_ok[g] = 1'b0;
          bits[g] = {bits[g][14:0], sdi[g]};
          nb[g]++;
        end
        if (in_fr[g] && !prev_cs[g] && csn[g]) begin
          chk(nb[g] == 16 && bits[g] == cur[g].frame, "frame_data", g, bits[g], cur[g].frame);
          chk(e == s + 33 * t && !sdi[g], "cs_rise_edge", g, e, s + 33 * t);
          chk(tim_ok[g] && sck[g] == 1'b0, "sck_rise_timing", g, tim_ok[g], 1);
        end
        if (fdone[g]) begin
          chk(in_fr[g] && ldacn[g] && e == s + 34 * t, "frame_done_edge", g, e, s + 34 * t);
          in_fr[g] = 1'b0;
        end
      end
      prev_sck[g] = sck[g];
      prev_cs[g]  = csn[g];
    end
    if (done_flag && !final_done) begin
      for (int g = 0; g < 2; g++) begin
        chk(exp_q[g].size() == 0 && !in_fr[g], "drain", g, exp_q[g].size(), 0);
      end
      final_done = 1'b1;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    d_rst = '1;
    d_sv  = '0;
    d_clr = '0;
    for (int g = 0; g < 2; g++) begin
      d_val[g]  = '0;
      m_free[g] = 0;
      m_pend[g] = '0;
    end
    m_full   = '0;
    exp_ovr  = '0;
    exp_busy = '0;
    exp_rst  = '0;
    tick();
    d_rst = '1;
    tick();
    idle(3);

    // single frame
    strobe(0, 10'h2A5, 1'b0);
    idle(140);
    // reset on the 8th sck rise, then a fresh frame
    strobe(0, 10'h2A5, 1'b0);
    idle(59);
    d_rst[0] = 1'b1;
    tick();
    idle(3);
    strobe(0, 10'h001, 1'b0);
    idle(140);
    // back-to-back through the pending buffer
    strobe(0, 10'h3FF, 1'b0);
    idle(9);
    strobe(0, 10'h000, 1'b0);
    idle(300);
    // overrun, then clear racing an overwrite
    strobe(0, 10'h0AA, 1'b0);
    idle(19);
    strobe(0, 10'h111, 1'b0);
    idle(4);
    strobe(0, 10'h222, 1'b0);
    idle(140);
    strobe(0, 10'h044, 1'b0);
    idle(4);
    strobe(0, 10'h055, 1'b1);
    idle(300);
    d_clr[0] = 1'b1;
    tick();
    idle(2);
    // strobe on the very edge a pending sample is launched
    strobe(0, 10'h100, 1'b0);
    idle(9);
    strobe(0, 10'h155, 1'b0);
    idle(126);
    strobe(0, 10'h1AA, 1'b0);
    idle(300);
    rand_run(0, 2000);
    idle(150);

    // CLK_DIV=2 instance
    strobe(1, 10'h3FF, 1'b0);
    idle(9);
    strobe(1, 10'h000, 1'b0);
    idle(150);
    rand_run(1, 4000);
    idle(200);

    done_flag = 1'b1;
    idle(3);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d/%0d", pass_cnt, chk_cnt);
    $fatal(1);
  end

endmodule
